// File: rtl/irq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_pkg                                                              |
// | Shared constants, FSM state type and clear-vector helper for the     |
// | interrupt request capture stage.                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package irq_pkg;

  localparam int NREQ = 32;
  localparam int IDW  = 6;

  // Two-state grant handshake FSM
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // One-hot vector selecting the line that is being served
  function automatic logic [NREQ-1:0] onehot32(input logic [IDW-1:0] id);
    return {{(NREQ-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_request_capture_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | priorityEncoder32                                                    |
// | Combinational 32-input priority encoder, bit 31 highest priority.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module priorityEncoder32
  import irq_pkg::*;
(
  input  logic [NREQ-1:0] req_vec,
  output logic [IDW-1:0]  enc_id,
  output logic            enc_valid
);

  // Later (higher) indices overwrite earlier ones, so the top set bit wins
  always_comb begin
    enc_id    = '0;
    enc_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_vec[i]) begin
        enc_id    = IDW'(i);
        enc_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_request_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_request_capture                                                  |
// | Rising-edge capture of 32 request lines into a pending register,     |
// | software masking, sticky overrun flags and a registered valid/ack    |
// | grant of the highest-priority eligible line.                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module irq_request_capture
  import irq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_in,
  input  logic            mask_we,
  input  logic [NREQ-1:0] mask_wdata,
  input  logic            grant_ack,
  input  logic            overrun_clr,
  output logic            grant_valid,
  output logic [IDW-1:0]  grant_id,
  output logic [NREQ-1:0] pending,
  output logic [NREQ-1:0] overrun,
  output logic [NREQ-1:0] mask
);

  logic [NREQ-1:0] req_q;
  logic [NREQ-1:0] edge_det;
  logic [NREQ-1:0] clr_vec;
  logic [NREQ-1:0] overrun_set;
  logic [NREQ-1:0] eligible;
  logic [IDW-1:0]  enc_id;
  logic            enc_valid;
  state_t          state;

  // Edge events, served-bit clear, lost-request detection and arbitration input
  always_comb begin
    edge_det    = req_in & ~req_q;
    clr_vec     = (grant_valid && grant_ack) ? onehot32(grant_id) : '0;
    overrun_set = edge_det & pending & ~clr_vec;
    eligible    = pending & ~mask;
  end

  priorityEncoder32 u_enc (
    .req_vec   (eligible),
    .enc_id    (enc_id),
    .enc_valid (enc_valid)
  );

  // Previous request levels for edge detection
  always_ff @(posedge clk) begin
    if (reset) req_q <= '0;
    else       req_q <= req_in;
  end

  // Pending latch: a new edge on a bit being served keeps it pending
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_vec) | edge_det;
  end

  // Sticky overruns; a fresh overrun survives a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset)            overrun <= '0;
    else if (overrun_clr) overrun <= overrun_set;
    else                  overrun <= overrun | overrun_set;
  end

  // Software mask register, 1 blocks the line from arbitration
  always_ff @(posedge clk) begin
    if (reset)        mask <= '0;
    else if (mask_we) mask <= mask_wdata;
  end

  // Grant FSM: capture the winner in IDLE, hold it stable through OFFER
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enc_valid) begin
            state       <= OFFER;
            grant_valid <= 1'b1;
            grant_id    <= enc_id;
          end
        end
        OFFER: begin
          if (grant_ack) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
